// File: rtl/shifter_unit.sv
// Multi-cycle barrel shifter: shifts or rotates an operand by up to STEP
// positions per clock and presents the final value with a one-cycle done pulse.
module shifter_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] num_shifts,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned CMP_W = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [CMP_W-1:0] amt_ext_c;
  logic [CNT_W-1:0] eff_c;
  logic [CNT_W-1:0] k_c;
  logic [WIDTH-1:0] shifted_c;

  // Effective amount; the compare runs at a width that holds both the raw amount and WIDTH.
  always_comb begin
    amt_ext_c = CMP_W'(num_shifts);
    eff_c     = '0;
    case (mode)
      OP_SHR, OP_SHRA, OP_SHL:
        eff_c = (amt_ext_c >= CMP_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(amt_ext_c);
      OP_ROR, OP_ROL:
        eff_c = CNT_W'(amt_ext_c % CMP_W'(WIDTH));
      default:
        eff_c = '0;
    endcase
  end

  // One step of the latched operation, at most STEP positions.
  always_comb begin
    k_c       = (rem_q > CNT_W'(STEP)) ? CNT_W'(STEP) : rem_q;
    shifted_c = work_q;
    case (mode_q)
      OP_SHR:  shifted_c = work_q >> k_c;
      OP_SHRA: shifted_c = $unsigned($signed(work_q) >>> k_c);
      OP_SHL:  shifted_c = work_q << k_c;
      OP_ROR:  shifted_c = (work_q >> k_c) | (work_q << (CNT_W'(WIDTH) - k_c));
      OP_ROL:  shifted_c = (work_q << k_c) | (work_q >> (CNT_W'(WIDTH) - k_c));
      default: shifted_c = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          rem_d   = eff_c;
          mode_d  = mode;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q != '0) begin
          work_d = shifted_c;
          rem_d  = rem_q - k_c;
        end else begin
          result_d = work_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == SHIFT);

endmodule

// File: tb/tb_shifter_unit.sv
// Directed bench for shifter_unit: three instances (STEP 1, 4, 8) run each vector in parallel.
module tb_shifter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [2:0]  mode;
  logic [31:0] data_in;
  logic [31:0] num_shifts;
  logic [31:0] res_w [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;

  int n_checks = 0;
  int n_errors = 0;
  int steps [3] = '{1, 4, 8};

  always #5 clk = ~clk;

  shifter_unit #(.WIDTH(32), .STEP(1), .AMT_W(32)) u_s1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode), .data_in(data_in),
    .num_shifts(num_shifts), .result(res_w[0]), .busy(busy_v[0]), .done(done_v[0]));
  shifter_unit #(.WIDTH(32), .STEP(4), .AMT_W(32)) u_s4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode), .data_in(data_in),
    .num_shifts(num_shifts), .result(res_w[1]), .busy(busy_v[1]), .done(done_v[1]));
  shifter_unit #(.WIDTH(32), .STEP(8), .AMT_W(32)) u_s8 (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode), .data_in(data_in),
    .num_shifts(num_shifts), .result(res_w[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one op on all instances; expect one done each at ceil(eff/STEP)+1 edges.
  task automatic run_op(input string tag, input logic [2:0] m, input logic [31:0] d,
                        input logic [31:0] n, input logic [31:0] exp, input int eff);
    int lat [3];
    int cnt [3];
    for (int j = 0; j < 3; j++) begin
      lat[j] = -1;
      cnt[j] = 0;
    end
    mode = m; data_in = d; num_shifts = n; start_v = 3'b111;
    @(posedge clk); #1;
    start_v = 3'b000; mode = 3'b011; data_in = ~d; num_shifts = 32'd3;
    chk($sformatf("%s_busy", tag), 32'(busy_v), 32'h7);
    for (int i = 1; i <= 36; i++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        if (done_v[j]) begin
          cnt[j]++;
          if (lat[j] < 0) lat[j] = i;
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_lat_s%0d", tag, steps[j]), 32'(lat[j]), 32'((eff + steps[j] - 1) / steps[j] + 1));
      chk($sformatf("%s_res_s%0d", tag, steps[j]), res_w[j], exp);
      chk($sformatf("%s_pulses_s%0d", tag, steps[j]), 32'(cnt[j]), 32'd1);
    end
  endtask

  initial begin
    int dones;
    int lat;
    reset = 1'b1; start_v = 3'b000; mode = 3'b000; data_in = '0; num_shifts = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", res_w[0], 32'h0);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(done_v), 32'h0);
    reset = 1'b0;

    run_op("shr1",    3'b000, 32'hFFFF_FFF0, 32'd1,        32'h7FFF_FFF8, 1);
    run_op("shra9",   3'b001, 32'h8000_0000, 32'd9,        32'hFFC0_0000, 9);
    run_op("shr64",   3'b000, 32'hA5A5_A5A5, 32'h40,       32'h0,         32);
    run_op("shl0",    3'b010, 32'hCAFE_F00D, 32'd0,        32'hCAFE_F00D, 0);
    run_op("shl4",    3'b010, 32'h0000_00FF, 32'd4,        32'h0000_0FF0, 4);
    run_op("ror36",   3'b011, 32'h1234_5678, 32'd36,       32'h8123_4567, 4);
    run_op("rol8",    3'b100, 32'h1234_5678, 32'd8,        32'h3456_7812, 8);
    run_op("rol32",   3'b100, 32'h1234_5678, 32'd32,       32'h1234_5678, 0);
    run_op("rsvd",    3'b101, 32'hDEAD_BEEF, 32'd7,        32'hDEAD_BEEF, 0);
    run_op("shra_pos",3'b001, 32'h7FFF_0000, 32'd100,      32'h0,         32);
    run_op("shra_neg",3'b001, 32'h8000_0000, 32'h8000_0028,32'hFFFF_FFFF, 32);

    // Start while busy is ignored (STEP=1 instance only).
    mode = 3'b010; data_in = 32'h1; num_shifts = 32'd3; start_v = 3'b001;
    @(posedge clk); #1;
    mode = 3'b011; data_in = 32'hFFFF; num_shifts = 32'd5;
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) start_v = 3'b000;
      if (done_v[0]) dones++;
    end
    chk("busy_ign_dones", 32'(dones), 32'd1);
    chk("busy_ign_res", res_w[0], 32'h8);

    // Start accepted in the done cycle; back-to-back results.
    mode = 3'b010; data_in = 32'h1; num_shifts = 32'd2; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000;
    lat = -1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) lat = i;
    end
    chk("b2b_a_lat", 32'(lat), 32'd3);
    chk("b2b_a_res", res_w[0], 32'h4);
    mode = 3'b000; data_in = 32'h80; num_shifts = 32'd4; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000;
    chk("b2b_no_double_done", 32'(done_v[0]), 32'h0);
    chk("b2b_b_busy", 32'(busy_v[0]), 32'h1);
    chk("b2b_hold", res_w[0], 32'h4);
    lat = -1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) lat = i;
    end
    chk("b2b_b_lat", 32'(lat), 32'd5);
    chk("b2b_b_res", res_w[0], 32'h8);

    // Reset mid-SHIFT aborts without a done pulse.
    mode = 3'b010; data_in = 32'h1; num_shifts = 32'd20; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = 3'b000;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy_v[0]), 32'h0);
    chk("abort_done", 32'(done_v[0]), 32'h0);
    chk("abort_res", res_w[0], 32'h0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shifter_unit.md
SHIFTER_UNIT -- requirements
Module: shifter_unit

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be >= 2.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per clock; SHALL satisfy 1 <= STEP <= WIDTH.
REQ-003 Parameter AMT_W, default 32: width of the shift-amount input.
REQ-004 Port clk  input  1: rising-edge clock, the single clock of the block.
REQ-005 Port reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port start  input  1: request; sampled only while busy=0.
REQ-007 Port mode  input  3: operation; 000 SHR (logical right), 001 SHRA (arithmetic right), 010 SHL, 011 ROR, 100 ROL, 101-111 reserved.
REQ-008 Port data_in  input  WIDTH: operand, captured with start.
REQ-009 Port num_shifts  input  AMT_W: unsigned shift amount, captured with start.
REQ-010 Port result  output  WIDTH: registered result.
REQ-011 Port busy  output  1: high while an operation is in progress.
REQ-012 Port done  output  1: single-cycle pulse marking a new, valid result.

Function
REQ-013 The block SHALL have states IDLE and SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-014 In IDLE, on a rising edge with start=1, the block SHALL load the working register with data_in, load the remaining-count register with eff, latch mode, and enter SHIFT.
REQ-015 eff definition, SHR/SHL/SHRA: min(num_shifts, WIDTH), using the full AMT_W-bit value, with no truncation before comparison.
REQ-016 eff definition, ROR/ROL: num_shifts mod WIDTH.
REQ-017 eff definition, reserved modes: 0.
REQ-018 In SHIFT with remaining > 0, each rising edge SHALL apply k = min(remaining, STEP) positions of the latched operation to the working register and decrement remaining by k.
REQ-019 In SHIFT with remaining = 0, the next rising edge SHALL copy the working register to result, drive done=1 for one cycle, and return to IDLE.
REQ-020 Latency: done SHALL be high during the cycle after the (ceil(eff/STEP)+1)-th rising edge following the start-capture edge.
REQ-021 SHR and SHL SHALL fill vacated bits with 0; an amount >= WIDTH SHALL yield all zeros.
REQ-022 SHRA SHALL fill vacated bits with data_in[WIDTH-1]; an amount >= WIDTH SHALL yield all copies of the sign bit.
REQ-023 ROR and ROL SHALL rotate without loss.
REQ-024 Reserved modes SHALL return data_in unchanged.
REQ-025 start while busy=1 SHALL be ignored, with no queuing; data_in, num_shifts and mode SHALL NOT affect an operation in progress.
REQ-026 start may be asserted in the same cycle done=1, because the block is in IDLE; that start SHALL be accepted.
REQ-027 result SHALL hold its value until the next done pulse.
REQ-028 Between done pulses, result SHALL NOT show intermediate values.
REQ-029 done SHALL never be asserted for two consecutive cycles.

Reset
REQ-030 On reset=1 at a rising edge: state->IDLE, result->0, busy->0, done->0, working and remaining registers->0.
REQ-031 Reset takes priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge at which reset=0.

Verification
REQ-033 WIDTH=32, STEP=1: SHR, data_in=32'hFFFFFFF0, num_shifts=1 -> result=32'h7FFFFFF8; done 2 edges after capture.
REQ-034 WIDTH=32, STEP=4: SHRA, data_in=32'h80000000, num_shifts=9 -> result=32'hFFC00000; done 4 edges after capture.
REQ-035 WIDTH=32, STEP=1: SHR, num_shifts=32'h00000040 -> result=0, latency 33 edges; SHL, num_shifts=0 -> result=data_in, latency 1 edge.
REQ-036 WIDTH=32, STEP=8: ROR, data_in=32'h12345678, num_shifts=36 -> result=32'h81234567 (eff=4); ROL by 8 of the same data_in -> 32'h34567812.
REQ-037 Second start during busy -> ignored, with a single done and the first operation's result; start during the done cycle -> accepted, with back-to-back results correct.
REQ-038 Reset asserted mid-SHIFT (STEP=1, SHL by 20) -> next cycle busy=0, done=0, result=0, and no done pulse follows.
